// File: rtl/storage_arbiter.sv
// Round-robin arbiter sharing the storage_controller port between instruction fetch and data.
// One transaction in flight; request fields are latched at grant and held on the port until the response.
module storage_arbiter #(
  parameter int          MEM_W          = 32,
  parameter logic [31:0] SRAM_LIMIT     = 32'h0000_0FFF,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_mode,
  input  logic               if_req_valid,
  input  logic [31:0]        if_req_addr,
  output logic               if_req_ready,
  output logic               if_rsp_valid,
  output logic [MEM_W-1:0]   if_rsp_data,
  output logic               if_rsp_err,
  input  logic               d_req_valid,
  input  logic               d_req_we,
  input  logic [31:0]        d_req_addr,
  input  logic [MEM_W-1:0]   d_req_wdata,
  input  logic [MEM_W/8-1:0] d_req_be,
  output logic               d_req_ready,
  output logic               d_rsp_valid,
  output logic [MEM_W-1:0]   d_rsp_data,
  output logic               d_rsp_err,
  output logic               mem_access,
  output logic               mem_is_writing,
  output logic [31:0]        mem_addr,
  output logic [MEM_W-1:0]   mem_d_in,
  output logic [MEM_W/8-1:0] mem_be,
  input  logic [MEM_W-1:0]   mem_d_out,
  input  logic               mem_out_valid,
  output logic               busy
);

  localparam int BE_W  = MEM_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic             owner;   // 0 = fetch, 1 = data
  logic             rr_ptr;  // requester preferred on the next tie
  logic [31:0]      addr_q;
  logic [MEM_W-1:0] wdata_q;
  logic [BE_W-1:0]  be_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt;

  logic             mem_access_q;
  logic             if_rsp_valid_q, if_rsp_err_q;
  logic             d_rsp_valid_q, d_rsp_err_q;
  logic [MEM_W-1:0] if_rsp_data_q, d_rsp_data_q;

  logic can_grant, grant_if, grant_d, d_illegal, wait_done;

  assign can_grant = (state == IDLE) && !prog_mode;
  assign grant_if  = can_grant && if_req_valid && (!d_req_valid || !rr_ptr);
  assign grant_d   = can_grant && d_req_valid && !grant_if;
  assign d_illegal = d_req_we && (d_req_addr >= SRAM_LIMIT);
  assign wait_done = mem_out_valid || (cnt == CNT_LAST);

  // rst gating keeps ready low while reset is asserted even if requesters are already valid.
  assign if_req_ready = grant_if && rst;
  assign d_req_ready  = grant_d && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      rr_ptr         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      we_q           <= 1'b0;
      cnt            <= '0;
      mem_access_q   <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rsp_data_q   <= '0;
    end else begin
      mem_access_q   <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_d) begin
            owner  <= grant_d;
            rr_ptr <= !grant_d;
            if (grant_d) begin
              addr_q  <= d_req_addr;
              we_q    <= d_req_we;
              wdata_q <= d_req_wdata;
              be_q    <= d_req_be;
            end else begin
              addr_q  <= if_req_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
              be_q    <= '1;
            end
            // Writes outside scratchpad never reach the controller.
            if (grant_d && d_illegal) begin
              state         <= RESP;
              d_rsp_valid_q <= 1'b1;
              d_rsp_err_q   <= 1'b1;
              d_rsp_data_q  <= '0;
            end else begin
              state        <= ISSUE;
              mem_access_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (wait_done) begin
            state <= RESP;
            if (owner) begin
              d_rsp_valid_q <= 1'b1;
              d_rsp_err_q   <= !mem_out_valid;
              d_rsp_data_q  <= (mem_out_valid && !we_q) ? mem_d_out : '0;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_err_q   <= !mem_out_valid;
              if_rsp_data_q  <= mem_out_valid ? mem_d_out : '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_access     = mem_access_q;
  assign mem_is_writing = we_q;
  assign mem_addr       = addr_q;
  assign mem_d_in       = wdata_q;
  assign mem_be         = be_q;
  assign if_rsp_valid   = if_rsp_valid_q;
  assign if_rsp_data    = if_rsp_data_q;
  assign if_rsp_err     = if_rsp_err_q;
  assign d_rsp_valid    = d_rsp_valid_q;
  assign d_rsp_data     = d_rsp_data_q;
  assign d_rsp_err      = d_rsp_err_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_storage_arbiter.sv
// Randomized and directed bench for storage_arbiter against a transaction-level reference model.
module tb_storage_arbiter;
  localparam int          TO  = 256;
  localparam logic [31:0] LIM = 32'h0000_0FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_mode = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0;
  logic [3:0]  d_req_be = '0;
  logic        d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic        mem_access, mem_is_writing, busy;
  logic [31:0] mem_addr, mem_d_in;
  logic [3:0]  mem_be;
  logic [31:0] mem_d_out = '0;
  logic        mem_out_valid = 1'b0;

  always #5 clk = ~clk;

  storage_arbiter #(.MEM_W(32), .SRAM_LIMIT(LIM), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_access(mem_access), .mem_is_writing(mem_is_writing), .mem_addr(mem_addr),
    .mem_d_in(mem_d_in), .mem_be(mem_be), .mem_d_out(mem_d_out),
    .mem_out_valid(mem_out_valid), .busy(busy)
  );

  int vectors = 0, miscompares = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Environment memory (behind the controller) and the reference model's shadow copy.
  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference model: one transaction record with its predicted cycle stamps.
  bit          m_act = 0, m_own = 0, m_ill = 0, m_we = 0, m_err = 0, m_rr = 0;
  int          m_gc = 0, m_ac = 0, m_rc = 0, m_lat = 0, force_lat = -1;
  logic [31:0] m_addr = '0, m_wd = '0, m_data = '0;
  logic [3:0]  m_be = '0;
  // Controller responder state.
  bit          e_pend = 0, e_we = 0;
  int          e_cyc = 0;
  logic [9:0]  e_idx = '0;
  // Observations used by the directed checks.
  bit          g_if, g_d;
  int          dut_gq[$];
  int          last_grant_cyc = -1, last_acc_cyc = -1, last_if_rsp_cyc = -1, last_d_rsp_cyc = -1;
  logic [31:0] last_if_data = '0, last_d_data = '0;
  logic        last_d_err = 1'b0, last_mem_we = 1'b0;
  logic [3:0]  last_mem_be = '0;

  task automatic step(input logic ifv, input logic [31:0] ifa, input logic dv, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe, input logic pm);
    bit idle_m, e_ifr, e_dr, e_ifv, e_dv, in_wait;
    int r;
    @(negedge clk);
    if_req_valid = ifv; if_req_addr = ifa;
    d_req_valid = dv; d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd; d_req_be = dbe;
    prog_mode = pm;
    in_wait = m_act && !m_ill && (cyc > m_ac) && (cyc < m_rc);
    if (e_pend && cyc == e_cyc) begin
      mem_out_valid = 1'b1;
      mem_d_out = e_we ? $urandom : env_mem[e_idx];
      e_pend = 0;
    end else if (!in_wait && $urandom_range(0, 7) == 0) begin
      mem_out_valid = 1'b1;  // stray pulse outside WAIT must be ignored
      mem_d_out = $urandom;
    end else begin
      mem_out_valid = 1'b0;
      mem_d_out = $urandom;
    end
    #1;
    idle_m = !m_act || (cyc > m_rc);
    e_ifr  = idle_m && !pm && ifv && (!dv || !m_rr);
    e_dr   = idle_m && !pm && dv && !e_ifr;
    chk("if_req_ready", 32'(if_req_ready), 32'(e_ifr));
    chk("d_req_ready", 32'(d_req_ready), 32'(e_dr));
    chk("busy", 32'(busy), 32'(m_act && cyc > m_gc && cyc <= m_rc));
    chk("mem_access", 32'(mem_access), 32'(m_act && !m_ill && cyc == m_ac));
    if (m_act && !m_ill && cyc >= m_ac && cyc < m_rc) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_is_writing", 32'(mem_is_writing), 32'(m_we));
      chk("mem_be", 32'(mem_be), 32'(m_be));
      chk("mem_d_in", mem_d_in, m_wd);
    end
    e_ifv = m_act && cyc == m_rc && !m_own;
    e_dv  = m_act && cyc == m_rc && m_own;
    chk("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_dv));
    if (e_ifv) begin
      chk("if_rsp_data", if_rsp_data, m_data);
      chk("if_rsp_err", 32'(if_rsp_err), 32'(m_err));
    end
    if (e_dv) begin
      chk("d_rsp_data", d_rsp_data, m_data);
      chk("d_rsp_err", 32'(d_rsp_err), 32'(m_err));
    end
    g_if = if_req_ready; g_d = d_req_ready;
    if (if_req_ready) dut_gq.push_back(0);
    if (d_req_ready) dut_gq.push_back(1);
    if (if_req_ready || d_req_ready) last_grant_cyc = cyc;
    if (if_rsp_valid) begin last_if_data = if_rsp_data; last_if_rsp_cyc = cyc; end
    if (d_rsp_valid) begin last_d_data = d_rsp_data; last_d_err = d_rsp_err; last_d_rsp_cyc = cyc; end
    if (mem_access) begin
      last_acc_cyc = cyc; last_mem_be = mem_be; last_mem_we = mem_is_writing;
      e_idx = mem_addr[11:2]; e_we = mem_is_writing;
      if (e_we) env_mem[e_idx] = merge(env_mem[e_idx], mem_d_in, mem_be);
      if (m_lat <= TO) begin e_pend = 1; e_cyc = cyc + m_lat; end
      else e_pend = 0;
    end
    if (e_ifr || e_dr) begin
      m_act = 1; m_gc = cyc; m_own = e_dr; m_rr = !e_dr;
      if (e_dr) begin m_addr = da; m_we = dwe; m_wd = dwd; m_be = dbe; end
      else begin m_addr = ifa; m_we = 0; m_wd = '0; m_be = 4'hF; end
      m_ill = m_we && (m_addr >= LIM);
      if (m_ill) begin
        m_ac = cyc; m_rc = cyc + 1; m_err = 1; m_data = '0;
      end else begin
        m_ac = cyc + 1;
        if (m_addr < LIM) m_lat = 1;
        else if (force_lat > 0) m_lat = force_lat;
        else begin
          r = $urandom_range(0, 15);
          m_lat = (r == 0) ? TO + 50 : (r == 1) ? TO : $urandom_range(1, 6);
        end
        m_err  = (m_lat > TO);
        m_rc   = cyc + 2 + (m_err ? TO : m_lat);
        m_data = (m_we || m_err) ? 32'h0 : ref_mem[m_addr[11:2]];
        if (m_we) ref_mem[m_addr[11:2]] = merge(ref_mem[m_addr[11:2]], m_wd, m_be);
      end
    end
    cyc++;
  endtask

  // Requester-side pending requests; a request is withdrawn once its ready is seen.
  logic        p_ifv = 0, p_dv = 0, p_dwe = 0, pm_g = 0;
  logic [31:0] p_ifa = '0, p_da = '0, p_dwd = '0;
  logic [3:0]  p_dbe = '0;

  task automatic cyc1();
    step(p_ifv, p_ifa, p_dv, p_dwe, p_da, p_dwd, p_dbe, pm_g);
    if (g_if) p_ifv = 0;
    if (g_d) p_dv = 0;
  endtask

  task automatic run_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((p_ifv || p_dv || (m_act && cyc <= m_rc)) && n < budget) begin cyc1(); n++; end
    chk(tag, 32'(!(p_ifv || p_dv || (m_act && cyc <= m_rc))), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      6: return 32'h0000_0FFC;
      7: return 32'h0000_0FFE;
      8: return 32'h0000_0FFF;
      9: return ($urandom_range(0, 1) == 0) ? 32'h0000_2000 : 32'h0001_0000;
      default: return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endcase
  endfunction

  task automatic new_d(input logic we, input logic [31:0] a, input logic [3:0] be);
    p_dv = 1; p_dwe = we; p_da = a; p_dwd = $urandom; p_dbe = be;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 32'h1357_0000 + i * 32'h0101;
      ref_mem[i] = 32'h1357_0000 + i * 32'h0101;
    end
    env_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;

    // Reset state with requesters already valid.
    if_req_valid = 1; d_req_valid = 1;
    #12;
    chk("rst_ctrl", {23'd0, if_req_ready, d_req_ready, if_rsp_valid, if_rsp_err, d_rsp_valid,
                     d_rsp_err, mem_access, mem_is_writing, busy}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", if_rsp_data | d_rsp_data | mem_d_in | {28'd0, mem_be}, 32'd0);
    if_req_valid = 0; d_req_valid = 0;
    @(negedge clk); rst = 1;

    // Both requesters always valid: grants alternate starting with fetch.
    dut_gq.delete();
    for (int n = 0; n < 200 && dut_gq.size() < 6; n++) begin
      if (!p_ifv) begin p_ifv = 1; p_ifa = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; end
      if (!p_dv) new_d(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom));
      cyc1();
    end
    p_ifv = 0; p_dv = 0;
    run_done(50, "rr_drain");
    for (int k = 0; k < 6; k++)
      chk("rr_order", (k < dut_gq.size()) ? 32'(dut_gq[k]) : 32'd2, 32'(k % 2));

    // Fetch read from scratchpad.
    p_ifv = 1; p_ifa = 32'h0000_0040;
    run_done(20, "if_rd_done");
    chk("if_rd_data", last_if_data, 32'hDEADBEEF);
    chk("if_acc_lat", 32'(last_acc_cyc - last_grant_cyc), 32'd1);
    chk("if_rsp_lat", 32'(last_if_rsp_cyc - last_grant_cyc), 32'd3);

    // Illegal write, then a legal partial write and its read-back.
    saved = last_acc_cyc;
    new_d(1, 32'h0000_2000, 4'hF);
    run_done(20, "ill_done");
    chk("ill_err", 32'(last_d_err), 32'd1);
    chk("ill_lat", 32'(last_d_rsp_cyc - last_grant_cyc), 32'd1);
    chk("ill_noacc", 32'(last_acc_cyc), 32'(saved));
    new_d(1, 32'h0000_0100, 4'b0011);
    run_done(20, "wr_done");
    chk("wr_be", 32'(last_mem_be), 32'h3);
    chk("wr_we", 32'(last_mem_we), 32'd1);
    chk("wr_err", 32'(last_d_err), 32'd0);
    new_d(0, 32'h0000_0100, 4'hF);
    run_done(20, "rb_done");

    // External read that never completes.
    force_lat = TO + 100;
    new_d(0, 32'h0001_0000, 4'hF);
    run_done(TO + 20, "to_done");
    force_lat = -1;
    chk("to_err", 32'(last_d_err), 32'd1);
    chk("to_data", last_d_data, 32'd0);
    chk("to_lat", 32'(last_d_rsp_cyc - last_acc_cyc - 1), 32'(TO));

    // prog_mode raised mid-WAIT.
    force_lat = 12;
    new_d(0, 32'h0000_2000, 4'hF);
    repeat (3) cyc1();
    force_lat = -1;
    pm_g = 1; p_ifv = 1; p_ifa = 32'h0000_0008;
    new_d(0, 32'h0000_000C, 4'hF);
    repeat (25) cyc1();
    pm_g = 0;
    saved = cyc;
    cyc1();
    chk("pm_grant_cyc", 32'(last_grant_cyc), 32'(saved));
    run_done(30, "pm_done");

    // Asynchronous reset in the middle of WAIT.
    force_lat = TO + 100;
    new_d(0, 32'h0001_0000, 4'hF);
    repeat (6) cyc1();
    force_lat = -1;
    @(negedge clk);
    if_req_valid = 1; d_req_valid = 1; mem_out_valid = 0;
    #3 rst = 0;
    #1;
    chk("arst_ctrl", {23'd0, if_req_ready, d_req_ready, if_rsp_valid, if_rsp_err, d_rsp_valid,
                      d_rsp_err, mem_access, mem_is_writing, busy}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    @(negedge clk);
    if_req_valid = 0; d_req_valid = 0;
    rst = 1;
    m_act = 0; m_rr = 0; e_pend = 0; p_ifv = 0; p_dv = 0;
    dut_gq.delete();
    p_ifv = 1; p_ifa = 32'h0000_0010;
    new_d(0, 32'h0000_0020, 4'hF);
    run_done(30, "arst_done");
    chk("arst_first", (dut_gq.size() > 0) ? 32'(dut_gq[0]) : 32'd2, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!p_ifv && $urandom_range(0, 3) == 0) begin p_ifv = 1; p_ifa = rand_addr(); end
      if (!p_dv && $urandom_range(0, 3) == 0) new_d(1'($urandom_range(0, 2) == 0), rand_addr(), 4'($urandom));
      if (p_ifv && $urandom_range(0, 31) == 0) p_ifv = 0;
      if (p_dv && $urandom_range(0, 31) == 0) p_dv = 0;
      if ($urandom_range(0, 29) == 0) pm_g = !pm_g;
      cyc1();
    end
    pm_g = 0; p_ifv = 0; p_dv = 0;
    run_done(TO + 20, "rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/storage_arbiter.md
Name: storage_arbiter

Overview:
- Shares the single storage_controller memory port between two requesters: instruction fetch (read-only) and data (read/write).
- Round-robin arbitration; one transaction outstanding at a time.
- Latches the winning request and holds address/data stable on the controller port for the whole transaction.
- Returns the response to the owning requester; a timeout guards against transactions that never complete.
- Sits between the core/vector-unit memory interfaces and storage_controller.

Parameters:
- MEM_W, 32, memory bus width in bits; byte-enable width is MEM_W/8.
- SRAM_LIMIT, 32'h0000_0FFF; addresses strictly below this are scratchpad SRAM, all others are external storage.
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before the transaction is abandoned with an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- prog_mode  in  1  programming mode active; blocks new grants
- if_req_valid  in  1  instruction fetch request
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  fetch read data
- if_rsp_err  out  1  fetch error (timeout)
- d_req_valid  in  1  data request
- d_req_we  in  1  data request is a write
- d_req_addr  in  32  data address
- d_req_wdata  in  32  write data
- d_req_be  in  MEM_W/8  byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data response pulse
- d_rsp_data  out  32  data read data
- d_rsp_err  out  1  data error (timeout or illegal write)
- mem_access  out  1  to controller memory_access
- mem_is_writing  out  1  to controller memory_is_writing
- mem_addr  out  32  to controller addr
- mem_d_in  out  32  to controller d_in
- mem_be  out  MEM_W/8  to controller mem_be
- mem_d_out  in  32  from controller d_out
- mem_out_valid  in  1  from controller out_valid
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; latched address/data/be/we registers 0; owner=IF; rr_ptr=IF; timeout counter 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection:
  - prog_mode=1: no grant; both ready=0.
  - Exactly one requester valid: that requester wins.
  - Both valid: rr_ptr wins.
  - The winner's ready is driven combinationally high in the same cycle.
- IDLE, on grant:
  - Latch addr/we/wdata/be (IF: we=0, be=all ones, wdata=0).
  - Set owner to the winner; set rr_ptr to the other requester.
  - Normal grant: go to ISSUE.
  - Data write with addr >= SRAM_LIMIT: illegal; do not issue; go to RESP with err=1.
- ISSUE (1 cycle): mem_access=1; mem_is_writing, mem_addr, mem_d_in, mem_be driven from the latches; next state WAIT; counter cleared.
- WAIT:
  - mem_access=0; mem_addr/mem_d_in/mem_be/mem_is_writing continue to be driven from the latches (the external path reads addr during its SPI sequence).
  - mem_out_valid=1: capture mem_d_out; err=0; go to RESP.
  - Otherwise increment counter; when counter reaches TIMEOUT_CYCLES-1 with no valid, go to RESP with err=1 and data 0.
  - mem_out_valid in the same cycle as expiry: valid wins, err=0.
- RESP (1 cycle):
  - Owner's rsp_valid=1 with registered rsp_data/rsp_err; the other requester's rsp_valid=0.
  - rsp_data is 0 for writes and errors.
  - Next state IDLE. No grant occurs in RESP; minimum back-to-back spacing is 4 cycles per transaction for SRAM.
- SRAM latency: request accepted at cycle T → mem_access at T+1 → mem_out_valid at T+2 → rsp_valid at T+3.
- prog_mode asserted mid-transaction: the current transaction completes normally (including timeout); new grants are blocked while prog_mode is high.
- Requesters may drop or change req fields after ready; the arbiter never samples req inputs outside IDLE.
- mem_out_valid while IDLE/ISSUE/RESP: ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it never wraps.

Test Plan:
- Reset mid-WAIT: rst low asynchronously → all outputs 0 immediately; state IDLE; after release, an IF request to 0x10 is granted first.
- IF read 0x0000_0040; model returns mem_out_valid with 0xDEADBEEF one cycle after mem_access → if_req_ready at T, mem_access only at T+1, if_rsp_valid with 0xDEADBEEF, err=0 at T+3.
- Both requesters valid every cycle, 6 transactions → grants alternate IF,D,IF,D,IF,D; no response is ever delivered to the non-owner.
- Data write 0x0000_2000 → no mem_access; d_rsp_valid with err=1 one cycle after ready. Data write 0x0000_0100, be=4'b0011 → mem_is_writing=1, mem_be=4'b0011.
- Data read 0x0001_0000 with model never asserting out_valid → mem_addr held at 0x0001_0000 throughout; d_rsp_err=1, d_rsp_data=0 exactly TIMEOUT_CYCLES cycles after WAIT entry.
- prog_mode raised during a WAIT → current response still delivered; pending requests get no ready until prog_mode falls; grant occurs in the first IDLE cycle after it falls.
